// File: rtl/ebi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ebi_bus_bridge
// Brief    : Turns asynchronous MCU EBI strobes into single-cycle clk-synchronous
//            register accesses on the internal pin-controller bus.
// Revision : 1.0  initial release
// ============================================================================
module ebi_bus_bridge #(
  parameter int                ADDR_W       = 21,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] IDLE_ADDR    = 21'h1FFFFF,
  parameter int                READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ebi_cs_n,
  input  logic              ebi_wr_n,
  input  logic              ebi_rd_n,
  input  logic [ADDR_W-1:0] ebi_addr,
  input  logic [DATA_W-1:0] ebi_wdata,
  output logic [DATA_W-1:0] ebi_rdata,
  output logic              ebi_rdata_oe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              proto_err
);

  localparam logic [3:0] c_READ_LAT = 4'(READ_LATENCY);
  localparam logic [1:0] c_SETTLED  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_BEAT  = 3'd1,
    S_WR_HOLD  = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_DRIVE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cs_sync;
  logic [1:0]        r_wr_sync;
  logic [1:0]        r_rd_sync;
  logic [1:0]        r_settle;
  logic              r_armed;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_proto_err;
  logic              w_wr_act;
  logic              w_rd_act;
  logic              w_wr_go;
  logic              w_rd_go;
  logic              w_cap_wr;
  logic              w_cap_rd;
  logic              w_latch;

  assign w_wr_act = !r_cs_sync[1] && !r_wr_sync[1];
  assign w_rd_act = !r_cs_sync[1] && !r_rd_sync[1];
  // A strobe already low when reset releases must be seen high before it counts
  assign w_wr_go  = r_armed && w_wr_act;
  assign w_rd_go  = r_armed && w_rd_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs_sync <= 2'b11;
      r_wr_sync <= 2'b11;
      r_rd_sync <= 2'b11;
      r_settle  <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_cs_sync <= {r_cs_sync[0], ebi_cs_n};
      r_wr_sync <= {r_wr_sync[0], ebi_wr_n};
      r_rd_sync <= {r_rd_sync[0], ebi_rd_n};
      if (r_settle != c_SETTLED) begin
        r_settle <= r_settle + 2'd1;
      end
      if (r_settle == c_SETTLED && !w_wr_act && !w_rd_act) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_wr    = 1'b0;
    w_cap_rd    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_go && !w_rd_go) begin
          w_state_nxt = S_WR_BEAT;
          w_cap_wr    = 1'b1;
        end else if (w_rd_go && !w_wr_go) begin
          w_state_nxt = S_RD_WAIT;
          w_cap_rd    = 1'b1;
        end
      end
      S_WR_BEAT: w_state_nxt = S_WR_HOLD;
      S_WR_HOLD: begin
        if (!w_wr_act) w_state_nxt = S_IDLE;
      end
      S_RD_WAIT: begin
        if (!w_rd_act) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_RD_DRIVE;
          w_latch     = 1'b1;
        end
      end
      S_RD_DRIVE: begin
        if (!w_rd_act) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 4'd0;
      r_addr      <= IDLE_ADDR;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_cap_wr || w_cap_rd) begin
        r_addr <= ebi_addr;
      end
      if (w_cap_wr) begin
        r_wdata <= ebi_wdata;
      end
      if (w_cap_rd) begin
        r_cnt <= c_READ_LAT;
      end else if (r_state == S_RD_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_latch) begin
        r_rdata <= bus_rdata;
      end
      if (w_wr_go && w_rd_go) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Address is parked off-decode except while a write beat or a read is live
  assign bus_addr     = (r_state == S_WR_BEAT || r_state == S_RD_WAIT) ? r_addr : IDLE_ADDR;
  assign bus_wdata    = r_wdata;
  assign bus_we       = (r_state == S_WR_BEAT);
  assign ebi_rdata    = r_rdata;
  assign ebi_rdata_oe = (r_state == S_RD_DRIVE);
  assign proto_err    = r_proto_err;

endmodule
`default_nettype wire
